uart_pid_ctrl: RTL and testbench
================================

UART_PID_CTRL -- requirements
Module: uart_pid_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 100000: the maximum number of idle clk_in cycles allowed between bytes of one frame.
REQ-002 SHALL provide ports in this order:
- clk_in, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- data_rdy, input, 1: one-cycle strobe from the UART receiver; a received byte is valid on data.
- data, input, 8: received byte.
- send_rdy, input, 1: high while the UART transmitter is idle.
- send, output, 1: one-cycle transmit request.
- send_data, output, 8: byte to transmit; held stable from the send pulse until send_rdy returns high.
- pid_out, input, 16: PID output word, readable as telemetry.
- kp, ki, kd, setpoint, output, 16 each: configuration registers.
- cfg_upd, output, 1: one-cycle pulse after any register write.
- busy, output, 1: high in every state except IDLE.

Function
REQ-003 SHALL parse frames of 5 bytes: 0xA5, ADDR, DHI, DLO, CSUM, where CSUM = ADDR^DHI^DLO.
REQ-004 SHALL use these FSM states: IDLE, ADDR, DHI, DLO, CSUM, EXEC, TX_SEND, TX_WAIT_LO, TX_WAIT_HI.
REQ-005 IDLE SHALL move to ADDR only on data_rdy with data==0xA5; any other byte SHALL be discarded silently.
REQ-006 ADDR->DHI->DLO->CSUM->EXEC SHALL advance one state per data_rdy strobe, capturing each byte.
REQ-007 EXEC SHALL last exactly one cycle and SHALL then enter TX_SEND with a response queue of 1 or 3 bytes.
REQ-008 In EXEC, a checksum mismatch SHALL queue the single byte 0x15 (NAK), and no register SHALL change.
REQ-009 Write addresses SHALL map 0x01->kp, 0x02->ki, 0x03->kd, 0x04->setpoint.
- Register value = {DHI,DLO}.
- The register updates at the EXEC clock edge.
- cfg_upd pulses in the following cycle.
- Response is the single byte 0x06 (ACK).
REQ-010 Read addresses 0x81-0x84 SHALL return the corresponding register; 0x85 SHALL return pid_out sampled in EXEC.
- Response is 3 bytes: HI, LO, HI^LO.
- DHI and DLO of a read frame are ignored.
REQ-011 Any other ADDR with a valid checksum SHALL queue NAK.
REQ-012 TX_SEND SHALL wait for send_rdy==1, then assert send for exactly one cycle with send_data set to the current queue byte, then enter TX_WAIT_LO.
REQ-013 TX_WAIT_LO SHALL wait for send_rdy==0 and then enter TX_WAIT_HI.
REQ-014 TX_WAIT_HI SHALL wait for send_rdy==1, then go to TX_SEND if queue bytes remain, else to IDLE.
REQ-015 send SHALL never be asserted on two consecutive cycles.
REQ-016 Bytes arriving (data_rdy) during EXEC or any TX state SHALL be dropped; the parser SHALL restart from IDLE only after the response completes.
REQ-017 Timeout SHALL apply in ADDR through CSUM:
- An inter-byte counter resets on each data_rdy.
- When it reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE with no response and no register change.
REQ-018 The counter width SHALL hold TIMEOUT_CYCLES, and the counter SHALL saturate rather than wrap.
REQ-019 A 0xA5 byte received in ADDR through CSUM SHALL be treated as ordinary payload, not as a resync.
REQ-020 If data_rdy and the timeout coincide in the same cycle, the byte SHALL be accepted and the counter cleared.
REQ-021 Writes SHALL be atomic: all 16 bits of a register change in the same cycle.

Reset
REQ-022 While reset==0, asynchronously:
- state = IDLE;
- kp = ki = kd = setpoint = 0x0000;
- send = 0, send_data = 0x00, cfg_upd = 0, busy = 0;
- response queue and timeout counter cleared.
REQ-023 Reset asserted mid-frame or mid-transmission SHALL abort the operation; no further send pulse SHALL occur after release until a new frame is parsed.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Write kp: A5 01 12 34 27 -> kp=0x1234; one cfg_upd pulse; one send with send_data=0x06.
- Bad checksum: A5 04 08 00 0D -> setpoint unchanged; single send of 0x15. Then A5 04 08 00 0C -> setpoint=0x0800 and ACK.
- Read: write ki=0x00AB, then A5 82 00 00 82 -> three sends 0x00, 0xAB, 0xAB. Each send is gated by a send_rdy low->high cycle, and no bytes are lost with send_rdy held low for 1000 cycles.
- Timeout, TIMEOUT_CYCLES=50: A5 01, then 60 idle cycles -> no response, kp unchanged. A following A5 02 00 05 07 -> ki=0x0005 and ACK.
- Reset mid-transmission: reset=0 for 3 cycles between the 1st and 2nd byte of a read response -> all registers 0x0000, no further send, busy=0. The next valid frame works normally.
- Byte dropped during TX, plus unknown address: a byte injected during TX_WAIT_LO is ignored. Frame A5 07 00 00 07 -> NAK 0x15.

Source files
------------

// File: rtl/uart_pid_ctrl.sv
// UART command parser for PID tuning: 5-byte frames write or read the gain and
// setpoint registers, and every frame that completes gets an ACK/NAK or 3-byte read reply.
module uart_pid_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        data_rdy,
    input  logic [7:0]  data,
    input  logic        send_rdy,
    output logic        send,
    output logic [7:0]  send_data,
    input  logic [15:0] pid_out,
    output logic [15:0] kp,
    output logic [15:0] ki,
    output logic [15:0] kd,
    output logic [15:0] setpoint,
    output logic        cfg_upd,
    output logic        busy
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CSUM,
        S_EXEC,
        S_TX_SEND,
        S_TX_WAIT_LO,
        S_TX_WAIT_HI
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] kp_q, kp_d;
    logic [15:0] ki_q, ki_d;
    logic [15:0] kd_q, kd_d;
    logic [15:0] sp_q, sp_d;
    logic [7:0]  q0_q, q0_d;
    logic [7:0]  q1_q, q1_d;
    logic [7:0]  q2_q, q2_d;
    logic [1:0]  q_len_q, q_len_d;
    logic [1:0]  q_idx_q, q_idx_d;
    logic        send_q, send_d;
    logic [7:0]  send_data_q, send_data_d;
    logic        cfg_upd_q, cfg_upd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        in_frame;
    logic        timeout;
    logic        csum_ok;
    logic [15:0] rd_val;
    logic [7:0]  q_byte;

    assign in_frame = (state_q == S_ADDR) || (state_q == S_DHI) ||
                      (state_q == S_DLO)  || (state_q == S_CSUM);
    assign timeout  = (cnt_q >= TO_MAX);
    assign csum_ok  = ((addr_q ^ dhi_q ^ dlo_q) == csum_q);

    always_comb begin
        rd_val = '0;
        case (addr_q)
            8'h81:   rd_val = kp_q;
            8'h82:   rd_val = ki_q;
            8'h83:   rd_val = kd_q;
            8'h84:   rd_val = sp_q;
            8'h85:   rd_val = pid_out;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        q_byte = q0_q;
        case (q_idx_q)
            2'd1:    q_byte = q1_q;
            2'd2:    q_byte = q2_q;
            default: q_byte = q0_q;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a byte arriving with the timeout wins over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (data_rdy && data == SYNC) state_d = S_ADDR;
            S_ADDR:       if (data_rdy) state_d = S_DHI;  else if (timeout) state_d = S_IDLE;
            S_DHI:        if (data_rdy) state_d = S_DLO;  else if (timeout) state_d = S_IDLE;
            S_DLO:        if (data_rdy) state_d = S_CSUM; else if (timeout) state_d = S_IDLE;
            S_CSUM:       if (data_rdy) state_d = S_EXEC; else if (timeout) state_d = S_IDLE;
            S_EXEC:       state_d = S_TX_SEND;
            S_TX_SEND:    if (send_rdy) state_d = S_TX_WAIT_LO;
            S_TX_WAIT_LO: if (!send_rdy) state_d = S_TX_WAIT_HI;
            S_TX_WAIT_HI: if (send_rdy) state_d = (q_idx_q < q_len_q) ? S_TX_SEND : S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        dlo_d       = dlo_q;
        csum_d      = csum_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        kd_d        = kd_q;
        sp_d        = sp_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        q_len_d     = q_len_q;
        q_idx_d     = q_idx_q;
        send_d      = 1'b0;
        send_data_d = send_data_q;
        cfg_upd_d   = 1'b0;
        cnt_d       = '0;

        // Counter only runs inside a frame; stops at TO_MAX because the FSM leaves there
        if (in_frame && !data_rdy && !timeout) cnt_d = cnt_q + 1'b1;

        case (state_q)
            S_ADDR: if (data_rdy) addr_d = data;
            S_DHI:  if (data_rdy) dhi_d  = data;
            S_DLO:  if (data_rdy) dlo_d  = data;
            S_CSUM: if (data_rdy) csum_d = data;
            S_EXEC: begin
                q_idx_d = '0;
                q_len_d = 2'd1;
                q0_d    = NAK;
                if (csum_ok) begin
                    case (addr_q)
                        8'h01, 8'h02, 8'h03, 8'h04: begin
                            case (addr_q)
                                8'h01:   kp_d = {dhi_q, dlo_q};
                                8'h02:   ki_d = {dhi_q, dlo_q};
                                8'h03:   kd_d = {dhi_q, dlo_q};
                                default: sp_d = {dhi_q, dlo_q};
                            endcase
                            cfg_upd_d = 1'b1;
                            q0_d      = ACK;
                        end
                        8'h81, 8'h82, 8'h83, 8'h84, 8'h85: begin
                            q0_d    = rd_val[15:8];
                            q1_d    = rd_val[7:0];
                            q2_d    = rd_val[15:8] ^ rd_val[7:0];
                            q_len_d = 2'd3;
                        end
                        default: q0_d = NAK;
                    endcase
                end
            end
            S_TX_SEND: begin
                if (send_rdy) begin
                    send_d      = 1'b1;
                    send_data_d = q_byte;
                    q_idx_d     = q_idx_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            csum_q      <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            sp_q        <= '0;
            q0_q        <= '0;
            q1_q        <= '0;
            q2_q        <= '0;
            q_len_q     <= '0;
            q_idx_q     <= '0;
            send_q      <= 1'b0;
            send_data_q <= '0;
            cfg_upd_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            dlo_q       <= dlo_d;
            csum_q      <= csum_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            kd_q        <= kd_d;
            sp_q        <= sp_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            q_len_q     <= q_len_d;
            q_idx_q     <= q_idx_d;
            send_q      <= send_d;
            send_data_q <= send_data_d;
            cfg_upd_q   <= cfg_upd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign send      = send_q;
    assign send_data = send_data_q;
    assign kp        = kp_q;
    assign ki        = ki_q;
    assign kd        = kd_q;
    assign setpoint  = sp_q;
    assign cfg_upd   = cfg_upd_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_pid_ctrl.sv
// Directed bench for uart_pid_ctrl: frame writes/reads, NAK paths, timeout,
// mid-response reset and byte dropping, against a simple UART transmitter model.
module tb_uart_pid_ctrl;

    logic        clk_in   = 1'b0;
    logic        reset    = 1'b0;
    logic        data_rdy = 1'b0;
    logic [7:0]  data     = 8'h00;
    logic        send_rdy = 1'b1;
    logic [15:0] pid_out  = 16'hBEEF;
    logic        send;
    logic [7:0]  send_data;
    logic [15:0] kp, ki, kd, setpoint;
    logic        cfg_upd;
    logic        busy;

    int tests    = 0;
    int fails    = 0;
    int tx_hold  = 4;
    int cfg_cnt  = 0;
    int cons_err = 0;
    int gate_err = 0;
    logic send_prev = 1'b0;
    logic [7:0] rx_log[$];

    uart_pid_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .data_rdy  (data_rdy),
        .data      (data),
        .send_rdy  (send_rdy),
        .send      (send),
        .send_data (send_data),
        .pid_out   (pid_out),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .setpoint  (setpoint),
        .cfg_upd   (cfg_upd),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    // Monitor: log transmitted bytes and cfg_upd pulses, flag protocol violations
    initial forever begin
        @(negedge clk_in);
        if (reset) begin
            if (send) begin
                rx_log.push_back(send_data);
                if (send_prev) cons_err++;
                if (!send_rdy) gate_err++;
            end
            if (cfg_upd) cfg_cnt++;
            send_prev = send;
        end else begin
            send_prev = 1'b0;
        end
    end

    // Transmitter model: goes busy two cycles after a request, idle again after tx_hold
    initial forever begin
        @(negedge clk_in);
        if (reset && send) begin
            repeat (2) @(negedge clk_in);
            send_rdy = 1'b0;
            repeat (tx_hold) @(negedge clk_in);
            send_rdy = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk_in);
        data     = b;
        data_rdy = 1'b1;
        @(negedge clk_in);
        data_rdy = 1'b0;
        data     = 8'h00;
        @(negedge clk_in);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] hi,
                         input logic [7:0] lo, input logic [7:0] cs);
        put_byte(8'hA5);
        put_byte(a);
        put_byte(hi);
        put_byte(lo);
        put_byte(cs);
    endtask

    task automatic wait_resp(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_in);
            if (rx_log.size() >= n && !busy) break;
        end
        @(negedge clk_in);
        check("resp_count", 32'(rx_log.size()), 32'(n));
        check("resp_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_send(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_in);
            if (send) begin
                seen = 1'b1;
                break;
            end
        end
        check("send_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_kp", 32'(kp), 32'h0);
        check("rst_ki", 32'(ki), 32'h0);
        check("rst_kd", 32'(kd), 32'h0);
        check("rst_sp", 32'(setpoint), 32'h0);
        check("rst_send", 32'(send), 32'h0);
        check("rst_send_data", 32'(send_data), 32'h0);
        check("rst_cfg_upd", 32'(cfg_upd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk_in);

        // Write kp
        frame(8'h01, 8'h12, 8'h34, 8'h27);
        wait_resp(1, 200);
        check("wr_kp_val", 32'(kp), 32'h1234);
        check("wr_kp_ack", 32'(rx_log[0]), 32'h06);
        check("wr_kp_cfg", 32'(cfg_cnt), 32'd1);

        // Bad checksum, then the corrected frame
        frame(8'h04, 8'h08, 8'h00, 8'h0D);
        wait_resp(2, 200);
        check("bad_cs_nak", 32'(rx_log[1]), 32'h15);
        check("bad_cs_sp", 32'(setpoint), 32'h0);
        check("bad_cs_cfg", 32'(cfg_cnt), 32'd1);
        frame(8'h04, 8'h08, 8'h00, 8'h0C);
        wait_resp(3, 200);
        check("wr_sp_ack", 32'(rx_log[2]), 32'h06);
        check("wr_sp_val", 32'(setpoint), 32'h0800);
        check("wr_sp_cfg", 32'(cfg_cnt), 32'd2);

        // Write ki then read it back with a slow transmitter
        frame(8'h02, 8'h00, 8'hAB, 8'hA9);
        wait_resp(4, 200);
        check("wr_ki_val", 32'(ki), 32'h00AB);
        check("wr_ki_ack", 32'(rx_log[3]), 32'h06);
        tx_hold = 1000;
        frame(8'h82, 8'h00, 8'h00, 8'h82);
        wait_resp(7, 5000);
        check("rd_ki_hi", 32'(rx_log[4]), 32'h00);
        check("rd_ki_lo", 32'(rx_log[5]), 32'hAB);
        check("rd_ki_x", 32'(rx_log[6]), 32'hAB);
        tx_hold = 4;

        // Timeout after A5 01
        put_byte(8'hA5);
        put_byte(8'h01);
        repeat (35) @(negedge clk_in);
        check("to_still_busy", 32'(busy), 32'd1);
        repeat (25) @(negedge clk_in);
        check("to_idle", 32'(busy), 32'd0);
        check("to_no_resp", 32'(rx_log.size()), 32'd7);
        check("to_kp_kept", 32'(kp), 32'h1234);
        frame(8'h02, 8'h00, 8'h05, 8'h07);
        wait_resp(8, 200);
        check("to_next_ki", 32'(ki), 32'h0005);
        check("to_next_ack", 32'(rx_log[7]), 32'h06);

        // Reset between first and second byte of a read response
        tx_hold = 20;
        frame(8'h81, 8'h00, 8'h00, 8'h81);
        wait_send(200);
        @(negedge clk_in);
        check("mid_rst_first", 32'(rx_log[8]), 32'h12);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        check("mid_rst_kp", 32'(kp), 32'h0);
        check("mid_rst_ki", 32'(ki), 32'h0);
        check("mid_rst_sp", 32'(setpoint), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sdata", 32'(send_data), 32'h0);
        reset = 1'b1;
        repeat (100) @(negedge clk_in);
        check("mid_rst_no_send", 32'(rx_log.size()), 32'd9);
        frame(8'h03, 8'h00, 8'h01, 8'h02);
        wait_resp(10, 200);
        check("post_rst_ack", 32'(rx_log[9]), 32'h06);
        check("post_rst_kd", 32'(kd), 32'h0001);

        // Byte injected in TX_WAIT_LO is dropped; unknown address gets NAK
        tx_hold = 30;
        frame(8'h83, 8'h00, 8'h00, 8'h83);
        wait_send(200);
        data     = 8'hA5;
        data_rdy = 1'b1;
        @(negedge clk_in);
        data_rdy = 1'b0;
        data     = 8'h00;
        wait_resp(13, 500);
        check("drop_rd_hi", 32'(rx_log[10]), 32'h00);
        check("drop_rd_lo", 32'(rx_log[11]), 32'h01);
        check("drop_rd_x", 32'(rx_log[12]), 32'h01);
        tx_hold = 4;
        frame(8'h07, 8'h00, 8'h00, 8'h07);
        wait_resp(14, 200);
        check("bad_addr_nak", 32'(rx_log[13]), 32'h15);

        // pid_out telemetry read
        frame(8'h85, 8'h00, 8'h00, 8'h85);
        wait_resp(17, 500);
        check("rd_pid_hi", 32'(rx_log[14]), 32'hBE);
        check("rd_pid_lo", 32'(rx_log[15]), 32'hEF);
        check("rd_pid_x", 32'(rx_log[16]), 32'h51);

        check("cfg_total", 32'(cfg_cnt), 32'd5);
        check("no_consec_send", 32'(cons_err), 32'd0);
        check("send_gated", 32'(gate_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
